// File: rtl/cgra_stream_pkg.sv
// Shared types and helpers for the CGRA stream routing fabric.
package cgra_stream_pkg;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    localparam logic MODE_STATIC = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    function automatic logic sel_in_range(input int unsigned sel, input int unsigned n);
        return sel < n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr+1, wrapping.
module rr_arbiter #(
    parameter int unsigned N_IN  = 4,
    parameter int unsigned SEL_W = $clog2(N_IN)
) (
    input  logic [N_IN-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N_IN-1:0]  gnt,
    output logic [SEL_W-1:0] gnt_idx
);

    // Priority is the wrapped distance from ptr+1; with no requester the
    // grant parks on ptr+1.
    always_comb begin
        int unsigned start;
        int unsigned best_d;
        int unsigned d;
        start   = (32'(ptr) + 1) % N_IN;
        best_d  = N_IN;
        d       = 0;
        gnt_idx = SEL_W'(start);
        for (int unsigned i = 0; i < N_IN; i++) begin
            d = (i + N_IN - start) % N_IN;
            if (req[i] && (d < best_d)) begin
                best_d  = d;
                gnt_idx = SEL_W'(i);
            end
        end
        gnt = N_IN'(1) << gnt_idx;
    end

endmodule

// File: rtl/stream_mux_nto1.sv
// Registered N-to-1 stream mux with static or round-robin selection and
// packet-atomic switching on the last flag.
module stream_mux_nto1
    import cgra_stream_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N_IN  = 4,
    parameter int unsigned SEL_W = $clog2(N_IN)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cfg_we,
    input  logic                  cfg_mode,
    input  logic [SEL_W-1:0]      cfg_sel,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [N_IN-1:0]       in_valid,
    input  logic [N_IN-1:0]       in_last,
    output logic [N_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic [SEL_W-1:0]      cur_sel,
    output logic                  cfg_err
);

    state_t             state_q;
    state_t             state_d;
    logic               mode_q;
    logic [SEL_W-1:0]   sel_q;
    logic [SEL_W-1:0]   lock_sel;
    logic [SEL_W-1:0]   rr_ptr;
    logic [N_IN-1:0]    arb_gnt;
    logic [SEL_W-1:0]   arb_idx;
    logic [SEL_W-1:0]   grant;
    logic [N_IN-1:0]    grant_oh;
    logic               grant_ok;
    logic [WIDTH-1:0]   grant_data;
    logic               grant_last;
    logic               ld;
    logic               hs;

    rr_arbiter #(
        .N_IN  (N_IN),
        .SEL_W (SEL_W)
    ) u_arb (
        .req     (in_valid),
        .ptr     (rr_ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    // An out-of-range static select shifts the one-hot grant out entirely.
    always_comb begin
        grant    = sel_q;
        grant_oh = N_IN'(1) << sel_q;
        grant_ok = sel_in_range(32'(sel_q), N_IN);
        if (state_q == LOCKED) begin
            grant    = lock_sel;
            grant_oh = N_IN'(1) << lock_sel;
            grant_ok = 1'b1;
        end else if (mode_q == MODE_RR) begin
            grant    = arb_idx;
            grant_oh = arb_gnt;
            grant_ok = 1'b1;
        end
    end

    always_comb begin
        grant_data = '0;
        grant_last = 1'b0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (grant_oh[i]) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
                grant_last = in_last[i];
            end
        end
    end

    assign ld = ~out_valid | out_ready;
    assign hs = |(in_valid & in_ready);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hs && !grant_last) state_d = LOCKED;
            LOCKED:  if (hs && grant_last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (ld && grant_ok && !reset) ? grant_oh : '0;
        cur_sel  = grant;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lock_sel <= '0;
            rr_ptr   <= SEL_W'(N_IN - 1);
        end else if (state_q == IDLE && hs) begin
            if (!grant_last) begin
                lock_sel <= grant;
            end
            if (mode_q == MODE_RR) begin
                rr_ptr <= grant;
            end
        end
    end

    // Config is captured immediately but only steers the grant while IDLE.
    always_ff @(posedge clock) begin
        if (reset) begin
            mode_q  <= MODE_STATIC;
            sel_q   <= '0;
            cfg_err <= 1'b0;
        end else if (cfg_we) begin
            mode_q <= cfg_mode;
            sel_q  <= cfg_sel;
            if (!sel_in_range(32'(cfg_sel), N_IN)) begin
                cfg_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (ld) begin
            out_valid <= hs;
            if (hs) begin
                out_data <= grant_data;
                out_last <= grant_last;
            end
        end
    end

endmodule

// File: doc/stream_mux_nto1.md
# stream_mux_nto1

Registered N-input, one-output stream multiplexer with valid/ready handshakes, in the CGRA routing fabric between PE output ports and the interconnect. It generalises the fixed 4-to-1 combinational data mux in three ways: parametrised width and input count, a static or round-robin selection mode, and packet-atomic switching on a `last` flag. The output is registered and sustains full throughput.

## Interface
- `WIDTH`, 32: data width per channel.
- `N_IN`, 4: number of input channels, 2..16.
- `SEL_W`, `$clog2(N_IN)`: select/grant width; derived, do not override.

- `clock`, in, 1: sole clock, rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `cfg_we`, in, 1: config write strobe.
- `cfg_mode`, in, 1: 0 = static select, 1 = round-robin.
- `cfg_sel`, in, SEL_W: static source index.
- `in_data`, in, N_IN*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
- `in_valid`, in, N_IN: per-channel valid.
- `in_last`, in, N_IN: per-channel end-of-packet.
- `in_ready`, out, N_IN: per-channel ready.
- `out_data`, out, WIDTH: registered output data.
- `out_valid`, out, 1: registered output valid.
- `out_last`, out, 1: registered output last.
- `out_ready`, in, 1: downstream ready.
- `cur_sel`, out, SEL_W: currently granted channel.
- `cfg_err`, out, 1: sticky; set when `cfg_sel >= N_IN` is written.

## Operation
- Config registers `mode_q` and `sel_q` capture `cfg_mode` and `cfg_sel` when `cfg_we` is high. The captured values are applied to arbitration only in state IDLE. A write during LOCKED stays pending and takes effect on the first IDLE cycle.
- A handshake occurs on input i when `in_valid[i] & in_ready[i]`. The output handshake is `out_valid & out_ready`.
- Load enable: `ld = ~out_valid | out_ready`.
- `in_ready[i] = ld & (i == grant) & grant_ok`. At most one bit is ever set.
- Static mode: `grant = sel_q`. `grant_ok = (sel_q < N_IN)`. When `grant_ok = 0`, nothing is accepted.
- Round-robin mode, in IDLE: `grant` is the first channel with `in_valid` set, searching from `rr_ptr+1` upward and wrapping modulo N_IN. If no channel is valid, `grant = rr_ptr+1` and `grant_ok = 1`.
- FSM state IDLE:
  - A handshake with `in_last = 0` latches `lock_sel = grant` and moves to LOCKED.
  - A handshake with `in_last = 1` stays in IDLE; this is a single-beat packet.
  - In both cases, in RR mode, `rr_ptr <= grant` on the handshake.
- FSM state LOCKED:
  - `grant = lock_sel` regardless of mode or pending config.
  - A handshake with `in_last = 1` returns to IDLE.
- Output register: when `ld` is high, `out_valid <= input handshake`. On a handshake, `out_data` and `out_last` load from the granted channel. `out_data` and `out_last` hold when there is no handshake.
- `cur_sel` shows `grant` in IDLE and `lock_sel` in LOCKED.
- `cfg_err` is set by `cfg_we` with an out-of-range `cfg_sel`. It is cleared only by reset.

## Timing
- Reset values:
  - `out_valid`, `out_last`, `out_data`, `cfg_err`: 0.
  - `in_ready`: 0 during reset.
  - `mode_q`, `sel_q`, `lock_sel`, `cur_sel`: 0.
  - FSM: IDLE.
  - `rr_ptr`: N_IN-1, so channel 0 has first priority.
- Latency: an input beat accepted in cycle t appears on `out_*` in cycle t+1.
- Throughput: one beat per cycle while `out_ready = 1`.
- `in_ready` depends combinationally on `out_ready`. There is no skid buffer.
- Backpressure: with `out_valid = 1` and `out_ready = 0`, all `in_ready` are 0 and the output holds stable.
- Simultaneous events:
  - A `cfg_we` in the same cycle as an IDLE handshake affects the next cycle only. The current grant uses the old `mode_q` and `sel_q`.
  - A handshake with `last = 1` in LOCKED and a pending config in the same cycle: the config applies in the next cycle.
- Reset mid-packet: returns to IDLE, drops the output beat, and clears the lock. Partial packets are not resumed.
- Wrap-around: `rr_ptr = N_IN-1` searches from 0.

## Structure
- Shared package `cgra_stream_pkg`:
  - state enum `{IDLE, LOCKED}`;
  - mode constants `MODE_STATIC = 1'b0` and `MODE_RR = 1'b1`;
  - `sel_in_range(sel, n)` function.
- One sub-module: `rr_arbiter` (N_IN requests, pointer in, one-hot grant plus index out). It is purely combinational.
- The config registers, FSM and output register live in `stream_mux_nto1`.

## Test plan
- Static, `cfg_sel = 2`, N_IN = 4, ch2 sends `0xA5A5_0001` with `last = 1`, `out_ready = 1`:
  - `in_ready = 4'b0100`;
  - `out_data = 0xA5A5_0001` one cycle later;
  - other channels never acknowledged.
- RR, all four channels valid with single-beat packets, `out_ready = 1`: grant order 0,1,2,3,0 on consecutive cycles; `out_data` follows one cycle behind.
- RR, ch1 sends a 3-beat packet while ch0 and ch2 are valid:
  - `cur_sel` holds 1 for all three beats;
  - ch2 is granted next;
  - there is no interleaving on `out_data`.
- Backpressure, `out_ready` low for 3 cycles mid-stream:
  - `out_valid` and `out_data` stay stable;
  - `in_ready = 0`;
  - no beat is lost or duplicated; the scoreboard matches.
- Config during packet: `cfg_we` with `cfg_sel = 3` while locked on ch0:
  - ch0 completes its packet;
  - ch3 is granted on the first IDLE cycle.
- Out-of-range select and reset, with N_IN = 3 and `cfg_sel = 3`:
  - `cfg_err` is 1 and all `in_ready` are 0;
  - `reset` asserted mid-packet clears `cfg_err`, `out_valid` and the lock in the next cycle.
